// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the 3x3 line buffer sequencer
package conv_pkg;

    localparam int DW    = 16;
    localparam int TAG_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Position tag riding alongside the pixel until its window is complete.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] row;
        logic [TAG_W-1:0] col;
    } win_tag_t;

endpackage

// File: rtl/raster_pos_cnt.sv
// rtl/raster_pos_cnt.sv - raster row/col counter with stride phase tracking
module raster_pos_cnt #(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int STRIDE = 1,
    localparam int CW = $clog2(IMG_W),
    localparam int RW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          adv,
    output logic          last,
    output logic          hit,
    output logic [RW-1:0] out_row,
    output logic [CW-1:0] out_col
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic          PH_LAST  = (STRIDE == 2);

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          row_ph;
    logic          col_ph;
    logic          col_wrap;
    logic          row_wrap;

    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);
    assign last     = col_wrap && row_wrap;
    // Phases sit at zero exactly on rows/cols that start an output window.
    assign hit      = (row >= ROW_TWO) && (col >= COL_TWO) && !row_ph && !col_ph;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row     <= '0;
            col     <= '0;
            row_ph  <= 1'b0;
            col_ph  <= 1'b0;
            out_row <= '0;
            out_col <= '0;
        end else if (clr) begin
            row     <= '0;
            col     <= '0;
            row_ph  <= 1'b0;
            col_ph  <= 1'b0;
            out_row <= '0;
            out_col <= '0;
        end else if (adv) begin
            if (col_wrap) begin
                col     <= '0;
                col_ph  <= 1'b0;
                out_col <= '0;
                if (row_wrap) begin
                    row     <= '0;
                    row_ph  <= 1'b0;
                    out_row <= '0;
                end else begin
                    row <= row + RW'(1);
                    if (row >= ROW_TWO) begin
                        row_ph <= (row_ph == PH_LAST) ? 1'b0 : ~row_ph;
                        if (row_ph == PH_LAST) begin
                            out_row <= out_row + RW'(1);
                        end
                    end
                end
            end else begin
                col <= col + CW'(1);
                if (col >= COL_TWO) begin
                    col_ph <= (col_ph == PH_LAST) ? 1'b0 : ~col_ph;
                    if (col_ph == PH_LAST) begin
                        out_col <= out_col + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/linebuffer_3x3_ctrl.sv
// rtl/linebuffer_3x3_ctrl.sv - frame sequencer driving a free-running 3x3 line buffer
module linebuffer_3x3_ctrl #(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int STRIDE = 1,
    parameter int DW     = conv_pkg::DW,
    parameter int LB_LEN = IMG_W,
    localparam int CW = $clog2(IMG_W),
    localparam int RW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] lb_din,
    output logic          win_valid,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          busy,
    output logic          frame_done,
    output logic          err_underrun
);

    import conv_pkg::*;

    if (LB_LEN != IMG_W) begin : g_len_chk
        $error("IMG_W must equal the line buffer length");
    end
    if (STRIDE != 1 && STRIDE != 2) begin : g_stride_chk
        $error("STRIDE must be 1 or 2");
    end
    if (IMG_H < 3) begin : g_height_chk
        $error("IMG_H must be at least 3");
    end

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_STREAM = ST_STREAM;
    localparam logic [1:0] S_DRAIN  = ST_DRAIN;
    localparam logic [1:0] S_DONE   = ST_DONE;

    logic [1:0]    state;
    logic          drain_cnt;
    logic          accept;
    logic          underrun;
    logic          last;
    logic          hit;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic [DW-1:0] lb_q;
    logic          err_q;
    win_tag_t      tag_next;
    win_tag_t      tag1;
    win_tag_t      tag2;
    logic          unused_tag_bits;

    assign in_ready = (state == S_STREAM);
    assign accept   = in_valid && in_ready;
    // The line buffer cannot stall, so a missing pixel mid-frame is fatal.
    assign underrun = in_ready && !in_valid;

    raster_pos_cnt #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .STRIDE (STRIDE)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (underrun),
        .adv     (accept),
        .last    (last),
        .hit     (hit),
        .out_row (out_row),
        .out_col (out_col)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            drain_cnt <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_STREAM;
                end
                S_STREAM: begin
                    if (underrun) begin
                        state <= S_IDLE;
                    end else if (last) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt) begin
                        state     <= S_DONE;
                        drain_cnt <= 1'b0;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        tag_next = '0;
        if (accept && hit) begin
            tag_next.valid = 1'b1;
            tag_next.row   = TAG_W'(out_row);
            tag_next.col   = TAG_W'(out_col);
        end
    end

    // Two tag stages: one for the lb_din register, one for the line buffer shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_q  <= '0;
            err_q <= 1'b0;
            tag1  <= '0;
            tag2  <= '0;
        end else begin
            lb_q  <= accept ? in_data : '0;
            err_q <= underrun;
            tag1  <= underrun ? '0 : tag_next;
            tag2  <= underrun ? '0 : tag1;
        end
    end

    assign lb_din       = lb_q;
    assign win_valid    = tag2.valid;
    assign win_row      = tag2.row[RW-1:0];
    assign win_col      = tag2.col[CW-1:0];
    assign busy         = (state != S_IDLE);
    assign frame_done   = (state == S_DONE);
    assign err_underrun = err_q;

    assign unused_tag_bits = ^{tag2.row[TAG_W-1:RW], tag2.col[TAG_W-1:CW]};

endmodule

// File: tb/tb_linebuffer_3x3_ctrl.sv
// tb/tb_linebuffer_3x3_ctrl.sv - self-checking bench for the 3x3 line buffer sequencer
module tb_linebuffer_3x3_ctrl;

    typedef struct {
        int              cyc;
        int              row;
        int              col;
        logic [8:0][15:0] taps;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] lb_din;
    logic        win_valid;
    logic [1:0]  win_row;
    logic [1:0]  win_col;
    logic        busy;
    logic        frame_done;
    logic        err_underrun;

    logic        s2_start;
    logic [15:0] s2_data;
    logic        s2_valid;
    logic        s2_ready;
    logic [15:0] s2_lb_din;
    logic        s2_win_valid;
    logic [2:0]  s2_win_row;
    logic [1:0]  s2_win_col;
    logic        s2_busy;
    logic        s2_frame_done;
    logic        s2_err_underrun;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int rdy_bad = 0;
    int ucyc = 0;

    logic [15:0] sr1 [0:10];
    logic [15:0] sr2 [0:10];
    rec_t q1 [$];
    rec_t q2 [$];
    int   fd1 [$];
    int   fd2 [$];
    int   ur1 [$];
    rec_t mrec1;
    rec_t mrec2;

    logic [15:0] pix1 [20];
    int          acc1 [20];
    logic [15:0] pixa [20];
    int          acca [20];
    logic [15:0] pix2 [20];
    int          acc2 [20];

    linebuffer_3x3_ctrl #(.IMG_W(4), .IMG_H(4), .STRIDE(1), .DW(16), .LB_LEN(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .lb_din       (lb_din),
        .win_valid    (win_valid),
        .win_row      (win_row),
        .win_col      (win_col),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_underrun (err_underrun)
    );

    linebuffer_3x3_ctrl #(.IMG_W(4), .IMG_H(5), .STRIDE(2), .DW(16), .LB_LEN(4)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (s2_start),
        .in_data      (s2_data),
        .in_valid     (s2_valid),
        .in_ready     (s2_ready),
        .lb_din       (s2_lb_din),
        .win_valid    (s2_win_valid),
        .win_row      (s2_win_row),
        .win_col      (s2_win_col),
        .busy         (s2_busy),
        .frame_done   (s2_frame_done),
        .err_underrun (s2_err_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Line buffer model: sr[0] is the newest sample, row pitch is 4.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 10; i > 0; i--) begin
            sr1[i] <= sr1[i-1];
            sr2[i] <= sr2[i-1];
        end
        sr1[0] <= lb_din;
        sr2[0] <= s2_lb_din;
    end

    always @(negedge clk) begin
        if (win_valid) begin
            mrec1.cyc = cyc;
            mrec1.row = int'(win_row);
            mrec1.col = int'(win_col);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    mrec1.taps[i*3+j] = sr1[(2-i)*4 + (2-j)];
            q1.push_back(mrec1);
        end
        if (s2_win_valid) begin
            mrec2.cyc = cyc;
            mrec2.row = int'(s2_win_row);
            mrec2.col = int'(s2_win_col);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    mrec2.taps[i*3+j] = sr2[(2-i)*4 + (2-j)];
            q2.push_back(mrec2);
        end
        if (frame_done) fd1.push_back(cyc);
        if (s2_frame_done) fd2.push_back(cyc);
        if (err_underrun) ur1.push_back(cyc);
        if (in_ready) rdy_cnt++;
        if (in_ready && (!busy || frame_done || err_underrun)) rdy_bad++;
        if (s2_ready && (!s2_busy || s2_frame_done)) rdy_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected windows come straight from the frame geometry and accept times.
    task automatic check_frame(input string nm, input int sel, input int h, input int s,
                               input logic [15:0] p [20], input int a [20]);
        rec_t o;
        int   n;
        for (int k = 0; k < 4*h; k++) begin
            int r;
            int c;
            r = k / 4;
            c = k % 4;
            if (r >= 2 && c >= 2 && (r-2) % s == 0 && (c-2) % s == 0) begin
                n = sel ? q2.size() : q1.size();
                chk({nm, "_win_present"}, (n > 0) ? 32'd1 : 32'd0, 32'd1);
                if (n > 0) begin
                    o = sel ? q2.pop_front() : q1.pop_front();
                    chk({nm, "_win_cycle"}, o.cyc, a[k] + 1);
                    chk({nm, "_win_row"}, o.row, (r-2) / s);
                    chk({nm, "_win_col"}, o.col, (c-2) / s);
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            chk({nm, "_tap"}, 32'(o.taps[i*3+j]), 32'(p[(r-2+i)*4 + (c-2+j)]));
                end
            end
        end
        n = sel ? fd2.size() : fd1.size();
        chk({nm, "_done_present"}, (n > 0) ? 32'd1 : 32'd0, 32'd1);
        if (n > 0) begin
            n = sel ? fd2.pop_front() : fd1.pop_front();
            chk({nm, "_done_cycle"}, n, a[4*h-1] + 2);
        end
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic run1(input int gap, input bit pokes);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == gap) begin
                in_valid = 1'b0;
                in_data  = '0;
                @(posedge clk); #1;
                ucyc = cyc;
                return;
            end
            in_valid = 1'b1;
            in_data  = pix1[k];
            start    = pokes && (k == 5);
            @(posedge clk); #1;
            acc1[k] = cyc;
            start   = 1'b0;
        end
        in_valid = 1'b0;
        in_data  = '0;
        start    = pokes;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = pokes;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clear_logs();
        q1.delete();
        q2.delete();
        fd1.delete();
        fd2.delete();
        ur1.delete();
        rdy_cnt = 0;
    endtask

    task automatic fill_seq(input int base);
        for (int k = 0; k < 20; k++) pix1[k] = 16'(base + k);
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 20; k++) pix1[k] = 16'($urandom_range(65535, 1));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        s2_start = 1'b0;
        s2_valid = 1'b0;
        s2_data  = '0;

        repeat (2) @(posedge clk); #1;
        chk("reset_outputs", 32'({in_ready, lb_din, win_valid, win_row, win_col,
                                  busy, frame_done, err_underrun}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_outputs", 32'({in_ready, lb_din, win_valid, busy, frame_done, err_underrun}), 32'd0);

        // Pixels 1..16, stride 1.
        clear_logs();
        fill_seq(1);
        run1(-1, 1'b0);
        check_frame("s1", 0, 4, 1, pix1, acc1);
        chk("s1_extra_windows", q1.size(), 0);
        chk("s1_ready_cycles", rdy_cnt, 16);
        chk("s1_no_underrun", ur1.size(), 0);

        // 4x5 frame at stride 2 on the second instance.
        for (int k = 0; k < 20; k++) pix2[k] = 16'($urandom_range(65535, 1));
        s2_start = 1'b1;
        @(posedge clk); #1;
        s2_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            s2_valid = 1'b1;
            s2_data  = pix2[k];
            @(posedge clk); #1;
            acc2[k] = cyc;
        end
        s2_valid = 1'b0;
        s2_data  = '0;
        repeat (3) @(posedge clk); #1;
        check_frame("s2", 1, 5, 2, pix2, acc2);
        chk("s2_extra_windows", q2.size(), 0);
        chk("s2_extra_done", fd2.size(), 0);

        // Underrun at pixel index 7, then a clean frame.
        clear_logs();
        fill_rand();
        run1(7, 1'b0);
        @(negedge clk); #1;
        chk("s3_busy_after_underrun", 32'(busy), 32'd0);
        chk("s3_underrun_pulses", ur1.size(), 1);
        if (ur1.size() > 0) chk("s3_underrun_cycle", ur1[0], ucyc);
        repeat (3) @(posedge clk); #1;
        chk("s3_underrun_once", ur1.size(), 1);
        chk("s3_no_windows", q1.size(), 0);
        chk("s3_no_done", fd1.size(), 0);
        chk("s3_ready_cycles", rdy_cnt, 8);
        clear_logs();
        fill_seq(1);
        run1(-1, 1'b0);
        check_frame("s3b", 0, 4, 1, pix1, acc1);
        chk("s3b_extra_windows", q1.size(), 0);

        // Spurious start pulses mid-stream, in drain and in done.
        clear_logs();
        fill_rand();
        run1(-1, 1'b1);
        chk("s4_start_in_done_ignored", 32'(busy), 32'd0);
        check_frame("s4", 0, 4, 1, pix1, acc1);
        chk("s4_extra_windows", q1.size(), 0);
        chk("s4_single_done", fd1.size(), 0);
        chk("s4_ready_cycles", rdy_cnt, 16);

        // Asynchronous reset after 9 accepts.
        clear_logs();
        fill_rand();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1;
            in_data  = pix1[k];
            @(posedge clk); #1;
        end
        chk("s5_busy_before_reset", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("s5_async_reset_outputs", 32'({in_ready, lb_din, win_valid, win_row, win_col,
                                           busy, frame_done, err_underrun}), 32'd0);
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_logs();
        fill_seq(101);
        run1(-1, 1'b0);
        check_frame("s5", 0, 4, 1, pix1, acc1);
        chk("s5_extra_windows", q1.size(), 0);

        // Back-to-back frames, second start on the first idle cycle.
        clear_logs();
        fill_rand();
        run1(-1, 1'b0);
        pixa = pix1;
        acca = acc1;
        fill_rand();
        run1(-1, 1'b0);
        check_frame("s6a", 0, 4, 1, pixa, acca);
        check_frame("s6b", 0, 4, 1, pix1, acc1);
        chk("s6_extra_windows", q1.size(), 0);
        chk("s6_ready_cycles", rdy_cnt, 32);

        chk("ready_outside_stream", rdy_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
